// File: rtl/quad_pkg.sv
// quad_pkg: shared state type, forward Gray order and edge classifier for quad_decoder
package quad_pkg;
  typedef enum logic {INIT, RUN} state_t;
  typedef struct packed {
    logic valid;
    logic dir;
    logic illegal;
  } qdir_t;
  localparam logic [1:0] GRAY_0 = 2'b00;
  localparam logic [1:0] GRAY_1 = 2'b01;
  localparam logic [1:0] GRAY_2 = 2'b11;
  localparam logic [1:0] GRAY_3 = 2'b10;
  function automatic logic [1:0] gray_pos(input logic [1:0] p);
    return p == GRAY_0 ? 2'd0 : p == GRAY_1 ? 2'd1 : p == GRAY_2 ? 2'd2 : 2'd3;
  endfunction
  // distance along the forward order: 1 = forward, 3 = reverse, 2 = both phases moved
  function automatic qdir_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] d;
    qdir_t r;
    d = gray_pos(cur) - gray_pos(prev);
    r.valid = d[0];
    r.dir = d == 2'd1;
    r.illegal = d == 2'd2;
    return r;
  endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: two-flop synchroniser plus stability filter for one quadrature phase
module quad_filter #(
  parameter int FILT_LEN = 4
) (
  input  logic clk_sys,
  input  logic Reset_n,
  input  logic raw,
  output logic filt
);
  logic [1:0] sync;
  always_ff @(posedge clk_sys or negedge Reset_n)
    if (!Reset_n) sync <= '0;
    else sync <= {sync[0], raw};
  generate
    if (FILT_LEN == 0) begin : g_bypass
      assign filt = sync[1];
    end else begin : g_filt
      localparam int CW = FILT_LEN < 2 ? 1 : $clog2(FILT_LEN);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk_sys or negedge Reset_n)
        if (!Reset_n) begin
          cnt <= '0;
          filt <= 1'b0;
        end else if (sync[1] == filt) begin
          cnt <= '0;
        end else if (cnt == CW'(FILT_LEN - 1)) begin
          cnt <= '0;
          filt <= sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
    end
  endgenerate
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: filtered 4x quadrature decode with position counter, read-and-clear delta and error count
module quad_decoder import quad_pkg::*; #(
  parameter int FILT_LEN = 4,
  parameter int POS_W = 16,
  parameter int DELTA_W = 8,
  parameter bit WRAP = 1
) (
  input  logic               clk_sys,
  input  logic               Reset_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clear_i,
  input  logic               rd_i,
  output logic               step_o,
  output logic               dir_o,
  output logic [POS_W-1:0]   pos_o,
  output logic [DELTA_W-1:0] delta_o,
  output logic               err_o,
  output logic [7:0]         err_cnt_o
);
  // INIT covers synchroniser plus filter settling so reset never yields a step
  localparam int INIT_LEN = FILT_LEN + 3;
  localparam int IW = $clog2(INIT_LEN + 1);
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [DELTA_W-1:0] D_MAX = {1'b0, {(DELTA_W-1){1'b1}}};
  localparam logic [DELTA_W-1:0] D_MIN = {1'b1, {(DELTA_W-1){1'b0}}};
  logic a_f, b_f;
  logic [1:0] cur, prev;
  logic [IW-1:0] init_cnt;
  state_t state, state_nxt;
  qdir_t qd;
  logic step_nxt, err_nxt, dir_nxt;
  logic [POS_W-1:0] pos_fwd, pos_rev, pos_nxt;
  logic [DELTA_W-1:0] delta_base, delta_nxt;
  logic [7:0] err_cnt_nxt;
  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk_sys(clk_sys), .Reset_n(Reset_n), .raw(enc_a), .filt(a_f));
  quad_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk_sys(clk_sys), .Reset_n(Reset_n), .raw(enc_b), .filt(b_f));
  assign cur = {a_f, b_f};
  assign qd = quad_dir(prev, cur);
  always_ff @(posedge clk_sys or negedge Reset_n)
    if (!Reset_n) begin
      state <= INIT;
      init_cnt <= '0;
      prev <= '0;
    end else begin
      state <= state_nxt;
      init_cnt <= state == INIT ? init_cnt + 1'b1 : init_cnt;
      prev <= cur;
    end
  always_comb state_nxt = state == INIT && init_cnt == IW'(INIT_LEN - 1) ? RUN : state;
  always_comb begin
    step_nxt = state == RUN && qd.valid;
    err_nxt = state == RUN && qd.illegal;
    dir_nxt = step_nxt ? qd.dir : dir_o;
  end
  always_comb begin
    pos_fwd = !WRAP && pos_o == POS_MAX ? pos_o : pos_o + 1'b1;
    pos_rev = !WRAP && pos_o == POS_MIN ? pos_o : pos_o - 1'b1;
    pos_nxt = clear_i ? '0 : step_nxt ? (qd.dir ? pos_fwd : pos_rev) : pos_o;
    delta_base = rd_i ? '0 : delta_o;
    delta_nxt = !step_nxt ? delta_base
              : qd.dir ? (delta_base == D_MAX ? delta_base : delta_base + 1'b1)
              : (delta_base == D_MIN ? delta_base : delta_base - 1'b1);
    err_cnt_nxt = err_nxt && err_cnt_o != 8'hFF ? err_cnt_o + 8'd1 : err_cnt_o;
  end
  always_ff @(posedge clk_sys or negedge Reset_n)
    if (!Reset_n) begin
      step_o <= 1'b0;
      dir_o <= 1'b0;
      err_o <= 1'b0;
      pos_o <= '0;
      delta_o <= '0;
      err_cnt_o <= '0;
    end else begin
      step_o <= step_nxt;
      dir_o <= dir_nxt;
      err_o <= err_nxt;
      pos_o <= pos_nxt;
      delta_o <= delta_nxt;
      err_cnt_o <= err_cnt_nxt;
    end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized scoreboard bench for quad_decoder against a pin-level behavioural model
module tb_quad_decoder;
  logic clk_sys = 1'b0;
  logic Reset_n = 1'b0;
  logic a0 = 1'b1, b0 = 1'b1, clr0 = 1'b0, rd0 = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, clr1 = 1'b0, rd1 = 1'b0;
  logic step0, dir0, err0, step1, dir1, err1, step2, dir2, err2;
  logic [15:0] pos0;
  logic [7:0] pos1, pos2, delta0, delta1, delta2, ecnt0, ecnt1, ecnt2;
  int n_chk = 0, n_fail = 0, cyc = 0, n_steps0 = 0;
  typedef struct {int cyc; bit err; bit dir; int pos; int pos_s; int delta; int ecnt;} ev_t;
  ev_t q0[$], q1[$];
  int rq0[$];
  localparam logic [1:0] G [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] p0 = 2'b11, p1 = 2'b00;
  int pm0 = 0, dm0 = 0, ec0 = 0, pw1 = 0, ps1 = 0, dm1 = 0, ec1 = 0;
  bit dir0m = 1'b0, dir1m = 1'b0;

  quad_decoder u_dut0 (.clk_sys(clk_sys), .Reset_n(Reset_n), .enc_a(a0), .enc_b(b0), .clear_i(clr0), .rd_i(rd0),
    .step_o(step0), .dir_o(dir0), .pos_o(pos0), .delta_o(delta0), .err_o(err0), .err_cnt_o(ecnt0));
  quad_decoder #(.FILT_LEN(0), .POS_W(8), .DELTA_W(8), .WRAP(1)) u_dut1 (.clk_sys(clk_sys), .Reset_n(Reset_n),
    .enc_a(a1), .enc_b(b1), .clear_i(clr1), .rd_i(rd1), .step_o(step1), .dir_o(dir1), .pos_o(pos1),
    .delta_o(delta1), .err_o(err1), .err_cnt_o(ecnt1));
  quad_decoder #(.FILT_LEN(0), .POS_W(8), .DELTA_W(8), .WRAP(0)) u_dut2 (.clk_sys(clk_sys), .Reset_n(Reset_n),
    .enc_a(a1), .enc_b(b1), .clear_i(clr1), .rd_i(rd1), .step_o(step2), .dir_o(dir2), .pos_o(pos2),
    .delta_o(delta2), .err_o(err2), .err_cnt_o(ecnt2));

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk_sys);
    #2;
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int gidx(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (G[i] == p) return i;
    return 0;
  endfunction
  function automatic logic [1:0] fwd(input logic [1:0] p);
    return G[(gidx(p) + 1) % 4];
  endfunction
  function automatic logic [1:0] rev(input logic [1:0] p);
    return G[(gidx(p) + 3) % 4];
  endfunction
  function automatic int wrapw(input int x, input int w);
    int m;
    m = 1 << w;
    return ((x + m / 2) & (m - 1)) - m / 2;
  endfunction
  function automatic int clampw(input int x, input int w);
    int h;
    h = 1 << (w - 1);
    return x > h - 1 ? h - 1 : x < -h ? -h : x;
  endfunction

  // model of the filtered decoder: the pin change shows up as an event 2+FILT_LEN+1 edges later
  task automatic edge0(input logic [1:0] np, input bit clr, input bit rd, input int gap);
    int d;
    ev_t e;
    if (rd) begin
      rq0.push_back(dm0);
      dm0 = 0;
    end
    d = (gidx(np) - gidx(p0) + 4) % 4;
    if (d == 2) ec0 = ec0 == 255 ? 255 : ec0 + 1;
    else if (d != 0) begin
      dir0m = d == 1;
      pm0 = wrapw(pm0 + (d == 1 ? 1 : -1), 16);
      dm0 = clampw(dm0 + (d == 1 ? 1 : -1), 8);
    end
    if (clr) pm0 = 0;
    e = '{cyc + 7, d == 2, dir0m, pm0, pm0, dm0, ec0};
    if (d != 0) q0.push_back(e);
    {a0, b0} = np;
    p0 = np;
    repeat (6) tick;
    clr0 = clr;
    rd0 = rd;
    tick;
    clr0 = 1'b0;
    rd0 = 1'b0;
    repeat (gap - 7) tick;
  endtask
  task automatic edge1(input logic [1:0] np, input bit clr, input int gap);
    int d;
    ev_t e;
    d = (gidx(np) - gidx(p1) + 4) % 4;
    if (d == 2) ec1 = ec1 == 255 ? 255 : ec1 + 1;
    else if (d != 0) begin
      dir1m = d == 1;
      pw1 = wrapw(pw1 + (d == 1 ? 1 : -1), 8);
      ps1 = clampw(ps1 + (d == 1 ? 1 : -1), 8);
      dm1 = clampw(dm1 + (d == 1 ? 1 : -1), 8);
    end
    if (clr) begin
      pw1 = 0;
      ps1 = 0;
    end
    e = '{cyc + 3, d == 2, dir1m, pw1, ps1, dm1, ec1};
    if (d != 0) q1.push_back(e);
    {a1, b1} = np;
    p1 = np;
    repeat (2) tick;
    clr1 = clr;
    tick;
    clr1 = 1'b0;
    repeat (gap - 3) tick;
  endtask
  task automatic read0;
    rq0.push_back(dm0);
    dm0 = 0;
    rd0 = 1'b1;
    tick;
    rd0 = 1'b0;
    tick;
  endtask

  always @(negedge clk_sys) if (Reset_n) begin
    ev_t e;
    if (step0) n_steps0++;
    if (rd0) begin
      if (rq0.size() == 0) chk("read0_unexpected", 1, 0);
      else chk("delta0_read", $signed(delta0), rq0.pop_front());
    end
    if (step0 || err0) begin
      if (q0.size() == 0) chk("dut0_spurious_event", {30'd0, step0, err0}, 0);
      else begin
        e = q0.pop_front();
        chk("dut0_latency", cyc, e.cyc);
        chk("dut0_err", err0, e.err);
        chk("dut0_step", step0, !e.err);
        chk("dut0_dir", dir0, e.dir);
        chk("dut0_pos", $signed(pos0), e.pos);
        chk("dut0_delta", $signed(delta0), e.delta);
        chk("dut0_errcnt", ecnt0, e.ecnt);
      end
    end
    if (step1 || err1 || step2 || err2) begin
      if (q1.size() == 0) chk("pair_spurious_event", {28'd0, step1, err1, step2, err2}, 0);
      else begin
        e = q1.pop_front();
        chk("pair_latency", cyc, e.cyc);
        chk("wrap_step", step1, !e.err);
        chk("sat_step", step2, !e.err);
        chk("wrap_err", err1, e.err);
        chk("sat_err", err2, e.err);
        chk("wrap_dir", dir1, e.dir);
        chk("wrap_pos", $signed(pos1), e.pos);
        chk("sat_pos", $signed(pos2), e.pos_s);
        chk("wrap_delta", $signed(delta1), e.delta);
        chk("sat_errcnt", ecnt2, e.ecnt);
      end
    end
  end

  initial begin
    int base;
    logic [1:0] np;
    repeat (3) tick;
    chk("rst_step", step0, 0);
    chk("rst_dir", dir0, 0);
    chk("rst_err", err0, 0);
    chk("rst_pos", pos0, 0);
    chk("rst_delta", delta0, 0);
    chk("rst_errcnt", ecnt0, 0);
    chk("rst_pos_wrap", pos1, 0);
    Reset_n = 1'b1;
    repeat (20) tick;
    chk("init_pos", pos0, 0);
    chk("init_errcnt", ecnt0, 0);
    edge0(2'b10, 1'b0, 1'b0, 20);
    chk("t1_pos", $signed(pos0), 1);
    clr0 = 1'b1;
    tick;
    clr0 = 1'b0;
    pm0 = 0;
    chk("idle_clear", pos0, 0);
    base = n_steps0;
    for (int i = 0; i < 160; i++) edge0(fwd(p0), 1'b0, 1'b0, 20);
    chk("t2_pos_fwd", $signed(pos0), pm0);
    for (int i = 0; i < 40; i++) edge0(rev(p0), 1'b0, 1'b0, 20);
    chk("t2_pos_rev", $signed(pos0), pm0);
    chk("t2_dir", dir0, 0);
    chk("t2_steps", n_steps0 - base, 200);
    for (int i = 0; i < 4; i++) begin
      a0 = ~a0;
      repeat ($urandom_range(1, 3)) tick;
      a0 = ~a0;
      repeat (20) tick;
    end
    chk("glitch_errcnt", ecnt0, ec0);
    edge0({~p0[1], p0[0]}, 1'b0, 1'b0, 20);
    chk("filtered_step_pos", $signed(pos0), pm0);
    edge0(~p0, 1'b0, 1'b0, 20);
    chk("illegal_errcnt", ecnt0, 1);
    for (int i = 0; i < 299; i++) edge0(~p0, 1'b0, 1'b0, 10);
    chk("errcnt_sat", ecnt0, 255);
    read0;
    for (int i = 0; i < 200; i++) edge0(fwd(p0), 1'b0, 1'b0, 10);
    chk("delta_sat", $signed(delta0), 127);
    edge0(fwd(p0), 1'b0, 1'b1, 20);
    chk("delta_after_read", $signed(delta0), 1);
    for (int i = 0; i < 30; i++) begin
      np = $urandom_range(0, 3);
      edge0(np, 1'b0, $urandom_range(0, 3) == 0, 12);
    end
    for (int i = 0; i < 127; i++) edge1(fwd(p1), 1'b0, 3);
    chk("pre_wrap_pos", $signed(pos1), 127);
    edge1(fwd(p1), 1'b0, 3);
    chk("wrap_pos_min", $signed(pos1), -128);
    chk("sat_pos_max", $signed(pos2), 127);
    for (int i = 0; i < 260; i++) edge1(rev(p1), 1'b0, 3);
    chk("sat_pos_min", $signed(pos2), -128);
    for (int i = 0; i < 40; i++) edge1(2'($urandom_range(0, 3)), 1'b0, 3);
    edge1(fwd(p1), 1'b1, 6);
    chk("clear_beats_step", pos1, 0);
    chk("clear_beats_step_sat", pos2, 0);
    edge1(fwd(p1), 1'b0, 6);
    Reset_n = 1'b0;
    #1;
    chk("midrst_pos", pos0, 0);
    chk("midrst_delta", delta0, 0);
    chk("midrst_errcnt", ecnt0, 0);
    chk("midrst_pos_wrap", pos1, 0);
    {a0, b0} = fwd(p0);
    p0 = fwd(p0);
    {a1, b1} = ~p1;
    p1 = ~p1;
    pm0 = 0; dm0 = 0; ec0 = 0; dir0m = 1'b0;
    pw1 = 0; ps1 = 0; dm1 = 0; ec1 = 0; dir1m = 1'b0;
    repeat (3) tick;
    Reset_n = 1'b1;
    repeat (30) tick;
    chk("post_rst_pos", pos0, 0);
    edge0(fwd(p0), 1'b0, 1'b0, 20);
    edge1(rev(p1), 1'b0, 6);
    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("rq0_drained", rq0.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
